// File: rtl/pdp8_pkg.sv
// rtl/pdp8_pkg.sv - shared PDP-8 widths and memory-stage state encoding
package pdp8_pkg;

  localparam int PDP8_WORD_W = 12;
  localparam int DEF_AW = 7;
  localparam int DEF_WW = PDP8_WORD_W;
  localparam int DEF_BW = 4;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

endpackage

// File: rtl/pdp8_serial_mem_if.sv
// rtl/pdp8_serial_mem_if.sv - CPU serial bus and host loader signals
interface pdp8_serial_mem_if import pdp8_pkg::*; #(
  parameter int AW = DEF_AW,
  parameter int WW = DEF_WW,
  parameter int BW = DEF_BW
);
  logic [AW-1:0] ma;
  logic [BW-1:0] ba;
  logic          write;
  logic          mb;
  logic          halt;
  logic          membus;
  logic          contin;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [WW-1:0] ld_data;
  logic          ld_ready;
  logic          ld_go;

  modport master (
    output ma, ba, write, mb, halt, ld_valid, ld_addr, ld_data, ld_go,
    input  membus, contin, ld_ready
  );

  modport slave (
    input  ma, ba, write, mb, halt, ld_valid, ld_addr, ld_data, ld_go,
    output membus, contin, ld_ready
  );
endinterface

// File: rtl/pdp8_word_store.sv
// rtl/pdp8_word_store.sv - word store with bit and word write ports, write-first reads
module pdp8_word_store import pdp8_pkg::*; #(
  parameter int AW = DEF_AW,
  parameter int WW = DEF_WW,
  parameter int BW = DEF_BW
) (
  input  logic          clk,
  input  logic          bit_we,
  input  logic [AW-1:0] bit_addr,
  input  logic [BW-1:0] bit_idx,
  input  logic          bit_din,
  input  logic          word_we,
  input  logic [AW-1:0] word_addr,
  input  logic [WW-1:0] word_din,
  input  logic [AW-1:0] rd_bit_addr,
  input  logic [BW-1:0] rd_bit_idx,
  output logic          rd_bit,
  input  logic [AW-1:0] rd_word_addr,
  output logic [WW-1:0] rd_word
);
  localparam logic [BW-1:0] WW_B = BW'(WW);

  logic [WW-1:0] mem [2**AW];
  logic [WW-1:0] bit_word;

  // Reads see the write landing on this same edge.
  function automatic logic [WW-1:0] fwd(input logic [AW-1:0] a);
    logic [WW-1:0] w;
    w = mem[a];
    if (word_we && word_addr == a) w = word_din;
    if (bit_we && bit_addr == a) w[bit_idx] = bit_din;
    return w;
  endfunction

  assign bit_word = fwd(rd_bit_addr);
  assign rd_bit   = (rd_bit_idx < WW_B) ? bit_word[rd_bit_idx] : 1'b0;
  assign rd_word  = fwd(rd_word_addr);

  always_ff @(posedge clk) begin
    if (word_we) mem[word_addr] <= word_din;
    if (bit_we) mem[bit_addr][bit_idx] <= bit_din;
  end
endmodule

// File: rtl/pdp8_serial_mem.sv
// rtl/pdp8_serial_mem.sv - serial PDP-8 memory stage with host loader and debug port
module pdp8_serial_mem import pdp8_pkg::*; #(
  parameter int AW = DEF_AW,
  parameter int WW = DEF_WW,
  parameter int BW = DEF_BW,
  parameter int CW = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  pdp8_serial_mem_if.slave    bus,
  input  logic [AW-1:0]       dbg_addr,
  output logic [WW-1:0]       dbg_data,
  output logic [CW-1:0]       run_cycles
);
  localparam logic [BW-1:0] WW_B = BW'(WW);

  state_t        state_q, state_d;
  logic          go_acc;
  logic          in_run;
  logic          ld_we;
  logic          bit_we;
  logic          rd_bit;
  logic [WW-1:0] dbg_word;
  logic          membus_q;
  logic          contin_q;

  assign in_run       = (state_q == ST_RUN);
  assign ld_we        = bus.ld_valid && !in_run;
  assign bit_we       = in_run && bus.write && (bus.ba < WW_B);
  assign bus.ld_ready = !in_run;
  assign bus.membus   = membus_q;
  assign bus.contin   = contin_q;

  always_comb begin
    state_d = state_q;
    go_acc  = 1'b0;
    case (state_q)
      ST_LOAD, ST_HALTED: begin
        if (bus.ld_go) begin
          state_d = ST_RUN;
          go_acc  = 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.halt) state_d = ST_HALTED;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  pdp8_word_store #(.AW(AW), .WW(WW), .BW(BW)) u_store (
    .clk          (clk),
    .bit_we       (bit_we),
    .bit_addr     (bus.ma),
    .bit_idx      (bus.ba),
    .bit_din      (bus.mb),
    .word_we      (ld_we),
    .word_addr    (bus.ld_addr),
    .word_din     (bus.ld_data),
    .rd_bit_addr  (bus.ma),
    .rd_bit_idx   (bus.ba),
    .rd_bit       (rd_bit),
    .rd_word_addr (dbg_addr),
    .rd_word      (dbg_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LOAD;
      membus_q   <= 1'b0;
      contin_q   <= 1'b0;
      dbg_data   <= '0;
      run_cycles <= '0;
    end else begin
      state_q  <= state_d;
      contin_q <= go_acc;
      membus_q <= in_run ? rd_bit : 1'b0;
      dbg_data <= dbg_word;
      // A fresh start clears the counter; resuming from HALTED keeps it.
      if (go_acc && state_q == ST_LOAD) begin
        run_cycles <= '0;
      end else if (in_run && run_cycles != {CW{1'b1}}) begin
        run_cycles <= run_cycles + 1'b1;
      end
    end
  end
endmodule
